card_dealer: RTL and testbench
==============================

CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter FLIP_PERIOD, default 1000, clk cycles between successive card flips (min 2).
REQ-002 SHALL have parameter DECK_SIZE, default 28, cards per player at game start (1..31).
REQ-003 SHALL have parameter SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  level, begins dealing from IDLE.
REQ-007 SHALL have port bell  in  1  level, a player hit the bell; freezes dealing.
REQ-008 SHALL have port resume  in  1  level, judgement done; clears table, restarts dealing.
REQ-009 SHALL have ports c1  out  2 and n1  out  3, player A face-up card color / number.
REQ-010 SHALL have ports c2  out  2 and n2  out  3, player B face-up card color / number.
REQ-011 SHALL have port flip_valid  out  1, one-cycle pulse when a new card is shown.
REQ-012 SHALL have port turn  out  1, next player to flip (0=A, 1=B).
REQ-013 SHALL have ports leftA, leftB  out  5 each, cards remaining in each player's deck.
REQ-014 SHALL have port game_over  out  1, level, high once both decks are empty.

Function
REQ-015 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting every cycle in all states.
REQ-016 SHALL derive a card as color = lfsr[4:3], number = (lfsr[2:0] mod 5) + 1; numbers 0, 6, 7 are never dealt.
REQ-017 SHALL treat color 0 with number 0 as "no card"; this is the empty-table value.
REQ-018 SHALL implement FSM states IDLE, RUN, HOLD, OVER.
REQ-019 IDLE: timer held at FLIP_PERIOD-1; start=1 -> RUN next cycle.
REQ-020 RUN: timer decrements each cycle; at timer==0 flip one card, reload FLIP_PERIOD-1, so flips are exactly FLIP_PERIOD cycles apart.
REQ-021 Flip: overwrite the card of player `turn` from REQ-016, decrement that player's count, toggle turn, pulse flip_valid in the same cycle the outputs change.
REQ-022 If the player indicated by turn has count 0, the other player SHALL flip instead, and turn SHALL point to the empty-deck player again afterwards.
REQ-023 RUN with bell=1 -> HOLD; timer frozen, no flip; bell SHALL win over a coincident timer==0 (no flip that cycle).
REQ-024 HOLD: cards and counts frozen; bell ignored; resume=1 -> RUN, c1/n1/c2/n2 cleared to 0, timer reloaded to FLIP_PERIOD-1.
REQ-025 A flip leaving leftA==0 and leftB==0 SHALL move to OVER on the next cycle; game_over=1 from that cycle.
REQ-026 OVER: all outputs frozen, start/bell/resume ignored; only reset exits.
REQ-027 start is ignored outside IDLE; resume is ignored outside HOLD.
REQ-028 Counts SHALL never decrement below 0 (no wrap).

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, c1=n1=c2=n2=0, flip_valid=0, turn=0, leftA=leftB=DECK_SIZE, game_over=0, timer=FLIP_PERIOD-1, lfsr=SEED.
REQ-030 Reset asserted mid-RUN or mid-HOLD SHALL abort the game with no flip_valid pulse on or after the reset edge.
REQ-031 After rst release, dealing SHALL NOT begin without a new start.

Verification (FLIP_PERIOD=4, DECK_SIZE=2)
REQ-032 Reset, start pulse at cycle 0 -> flip_valid at cycles 4, 8, 12, 16; turn 0,1,0,1 before each; leftA/leftB end at 0/0; game_over=1 at cycle 17.
REQ-033 Every dealt card over 1000 games with varied start times -> n in 1..5, c in 0..3, each of 5 numbers observed.
REQ-034 bell=1 in the same cycle as timer==0 -> no flip_valid, state HOLD, counts unchanged; resume 10 cycles later -> c1=n1=c2=n2=0, next flip exactly 4 cycles after resume.
REQ-035 Empty-deck skip: DECK_SIZE=2, hold A's flips by forcing order so leftA=0, leftB=1 with turn=0 -> next flip updates c2/n2, leftB=0, then OVER.
REQ-036 rst=0 asserted asynchronously between edges during HOLD -> outputs reach reset values (REQ-029) before the next clk edge; start ignored until released.

Source files
------------

// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
// Module      : card_dealer
// Description : Two-player card dealer; flips a pseudo-random card on a fixed
//               period, alternating players, with bell hold and game over.
// Revision    : 1.0 - initial release
// ============================================================================
module card_dealer #(
    parameter int          FLIP_PERIOD = 1000,
    parameter int          DECK_SIZE   = 28,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bell,
    input  logic       resume,
    output logic [1:0] c1,
    output logic [2:0] n1,
    output logic [1:0] c2,
    output logic [2:0] n2,
    output logic       flip_valid,
    output logic       turn,
    output logic [4:0] leftA,
    output logic [4:0] leftB,
    output logic       game_over
);

    localparam int            TW     = $clog2(FLIP_PERIOD);
    localparam logic [TW-1:0] RELOAD = TW'(FLIP_PERIOD - 1);
    localparam logic [4:0]    DECK   = 5'(DECK_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [TW-1:0] timer;

    logic       feedback;
    logic [1:0] card_c;
    logic [2:0] card_n;
    logic       skip;
    logic       flip_b;

    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Numbers 1..5 only: fold the three raw values above 4 back onto 1..3.
    always_comb begin
        card_c = lfsr[4:3];
        case (lfsr[2:0])
            3'd5:    card_n = 3'd1;
            3'd6:    card_n = 3'd2;
            3'd7:    card_n = 3'd3;
            default: card_n = lfsr[2:0] + 3'd1;
        endcase
    end

    // An empty deck hands the flip to the other player without moving turn.
    assign skip   = turn ? (leftB == 5'd0) : (leftA == 5'd0);
    assign flip_b = turn ^ skip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            timer      <= RELOAD;
            c1         <= 2'd0;
            n1         <= 3'd0;
            c2         <= 2'd0;
            n2         <= 3'd0;
            flip_valid <= 1'b0;
            turn       <= 1'b0;
            leftA      <= DECK;
            leftB      <= DECK;
            game_over  <= 1'b0;
        end else begin
            lfsr       <= {lfsr[14:0], feedback};
            flip_valid <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= RELOAD;
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (leftA == 5'd0 && leftB == 5'd0) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else if (bell) begin
                        state <= HOLD;
                    end else if (timer == '0) begin
                        timer      <= RELOAD;
                        flip_valid <= 1'b1;
                        turn       <= skip ? turn : ~turn;
                        if (flip_b) begin
                            c2 <= card_c;
                            n2 <= card_n;
                            if (leftB != 5'd0) begin
                                leftB <= leftB - 5'd1;
                            end
                        end else begin
                            c1 <= card_c;
                            n1 <= card_n;
                            if (leftA != 5'd0) begin
                                leftA <= leftA - 5'd1;
                            end
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                HOLD: begin
                    if (resume) begin
                        state <= RUN;
                        timer <= RELOAD;
                        c1    <= 2'd0;
                        n1    <= 3'd0;
                        c2    <= 2'd0;
                        n2    <= 3'd0;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_card_dealer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_card_dealer
// Description : Self-checking bench for card_dealer (FLIP_PERIOD=4, DECK_SIZE=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_card_dealer;

    localparam int          FP   = 4;
    localparam int          DS   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       start  = 1'b0;
    logic       bell   = 1'b0;
    logic       resume = 1'b0;
    logic [1:0] c1, c2;
    logic [2:0] n1, n2;
    logic       flip_valid, turn, game_over;
    logic [4:0] leftA, leftB;

    card_dealer #(.FLIP_PERIOD(FP), .DECK_SIZE(DS), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .bell(bell), .resume(resume),
        .c1(c1), .n1(n1), .c2(c2), .n2(n2), .flip_valid(flip_valid),
        .turn(turn), .leftA(leftA), .leftB(leftB), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int       n_chk = 0;
    int       n_fail = 0;
    int       edge_cnt;
    bit [4:0] seen = '0;

    typedef struct {
        int         edge_n;
        bit         player;
        logic [1:0] c;
        logic [2:0] n;
    } flip_t;
    flip_t sb[$];

    typedef struct {
        logic        start, bell, resume;
        logic [12:0] exp;
    } row_t;
    row_t rows[20];

    // Rising edges since reset release; the DUT LFSR has shifted this many times.
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_after(int k);
        logic [15:0] v = SEED;
        for (int i = 0; i < k; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        return v;
    endfunction

    function automatic logic [4:0] card_at(int e);
        logic [15:0] v = lfsr_after(e - 1);
        logic [2:0]  num = (v[2:0] % 3'd5) + 3'd1;
        return {v[4:3], num};
    endfunction

    task automatic push_flip(int e, bit p);
        logic [4:0] cd = card_at(e);
        sb.push_back('{edge_n: e, player: p, c: cd[4:3], n: cd[2:0]});
    endtask

    function automatic row_t mk(logic st, logic b, logic r, logic fv, logic tu,
                                logic [4:0] la, logic [4:0] lb, logic go);
        row_t x;
        x.start = st; x.bell = b; x.resume = r;
        x.exp = {fv, tu, la, lb, go};
        return x;
    endfunction

    task automatic cycles(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        start = 1'b0; bell = 1'b0; resume = 1'b0;
        @(negedge clk); rst = 1'b0;
        cycles(2);
        rst = 1'b1;
    endtask

    task automatic wait_over(string name, int budget);
        int k = 0;
        while (!game_over && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, game_over}, 32'd1);
    endtask

    always @(negedge clk) begin : monitor
        flip_t      e;
        logic [4:0] act;
        if (rst && flip_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_flip: flip_valid=1 at edge %0d, required no flip", edge_cnt);
            end else begin
                e   = sb.pop_front();
                act = e.player ? {c2, n2} : {c1, n1};
                check($sformatf("flip_edge_exp%0d", e.edge_n), edge_cnt, e.edge_n);
                check($sformatf("flip_card_edge%0d", e.edge_n), {27'd0, act}, {27'd0, e.c, e.n});
                check("card_number_range", {31'd0, (act[2:0] >= 3'd1 && act[2:0] <= 3'd5)}, 32'd1);
                if (act[2:0] >= 3'd1 && act[2:0] <= 3'd5) seen[act[2:0] - 3'd1] = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         e0, r_edge;
        logic [4:0] exp_b;

        rows[0] = mk(1, 0, 0, 0, 0, 5'd2, 5'd2, 0);
        for (int i = 1;  i < 4;  i++) rows[i] = mk(0, 0, 0, 0, 0, 5'd2, 5'd2, 0);
        rows[4] = mk(0, 0, 0, 1, 1, 5'd1, 5'd2, 0);
        for (int i = 5;  i < 8;  i++) rows[i] = mk(0, 0, 0, 0, 1, 5'd1, 5'd2, 0);
        rows[8] = mk(0, 0, 0, 1, 0, 5'd1, 5'd1, 0);
        for (int i = 9;  i < 12; i++) rows[i] = mk(0, 0, 0, 0, 0, 5'd1, 5'd1, 0);
        rows[12] = mk(0, 0, 0, 1, 1, 5'd0, 5'd1, 0);
        for (int i = 13; i < 16; i++) rows[i] = mk(0, 0, 0, 0, 1, 5'd0, 5'd1, 0);
        rows[16] = mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 0);
        rows[17] = mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 1);
        rows[18] = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 1);
        rows[19] = mk(0, 1, 1, 0, 0, 5'd0, 5'd0, 1);

        // Full game: start pulse, four alternating flips, then game over.
        do_reset();
        check("reset_state", {9'd0, c1, n1, c2, n2, flip_valid, turn, leftA, leftB, game_over},
              {9'd0, 10'd0, 1'b0, 1'b0, 5'd2, 5'd2, 1'b0});
        e0 = edge_cnt + 1;
        for (int k = 1; k <= 4; k++) push_flip(e0 + 4 * k, k[0] == 1'b0);
        for (int i = 0; i < 20; i++) begin
            start = rows[i].start; bell = rows[i].bell; resume = rows[i].resume;
            @(negedge clk);
            check($sformatf("row%0d", i), {19'd0, flip_valid, turn, leftA, leftB, game_over},
                  {19'd0, rows[i].exp});
        end
        start = 1'b0; bell = 1'b0; resume = 1'b0;
        check("sb_empty_full_game", sb.size(), 0);

        // Bell coincident with timer==0, then resume ten cycles later.
        do_reset();
        e0 = edge_cnt + 1;
        push_flip(e0 + 4, 1'b0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        cycles(7);
        bell = 1'b1; @(negedge clk); bell = 1'b0;
        check("bell_wins", {26'd0, flip_valid, leftA, leftB}, {26'd0, 1'b0, 5'd1, 5'd2});
        start = 1'b1; @(negedge clk); start = 1'b0;
        cycles(8);
        r_edge = edge_cnt + 1;
        push_flip(r_edge + 4, 1'b1);
        resume = 1'b1; @(negedge clk); resume = 1'b0;
        check("resume_clears", {22'd0, c1, n1, c2, n2}, 32'd0);
        check("hold_frozen", {21'd0, turn, leftA, leftB}, {21'd0, 1'b1, 5'd1, 5'd2});
        cycles(4);
        exp_b = card_at(r_edge + 4);
        resume = 1'b1; @(negedge clk); resume = 1'b0;
        check("resume_ignored_in_run", {22'd0, c1, n1, c2, n2}, {22'd0, 5'd0, exp_b});
        push_flip(r_edge + 8, 1'b0);
        push_flip(r_edge + 12, 1'b1);
        wait_over("bell_game_over", 30);
        check("sb_empty_bell", sb.size(), 0);

        // Asynchronous reset between edges while in HOLD.
        do_reset();
        e0 = edge_cnt + 1;
        push_flip(e0 + 4, 1'b0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        cycles(4);
        bell = 1'b1; @(negedge clk); bell = 1'b0;
        cycles(2);
        @(posedge clk); #2 rst = 1'b0;
        #1 check("async_reset", {9'd0, c1, n1, c2, n2, flip_valid, turn, leftA, leftB, game_over},
                 {9'd0, 10'd0, 1'b0, 1'b0, 5'd2, 5'd2, 1'b0});
        start = 1'b1;
        cycles(2);
        start = 1'b0; rst = 1'b1;
        cycles(12);
        check("no_deal_without_start", {17'd0, leftA, leftB, c1, n1}, {17'd0, 5'd2, 5'd2, 5'd0});
        check("sb_empty_async", sb.size(), 0);

        // Empty-deck skip: A empty, B holds one card, turn forced back to A.
        do_reset();
        e0 = edge_cnt + 1;
        push_flip(e0 + 4, 1'b0);
        push_flip(e0 + 8, 1'b1);
        push_flip(e0 + 12, 1'b0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        cycles(12);
        check("pre_skip", {21'd0, turn, leftA, leftB}, {21'd0, 1'b1, 5'd0, 5'd1});
        bell = 1'b1; @(negedge clk); bell = 1'b0;
        force dut.turn = 1'b0;
        cycles(2);
        r_edge = edge_cnt + 1;
        push_flip(r_edge + 4, 1'b1);
        resume = 1'b1; @(negedge clk); resume = 1'b0;
        cycles(4);
        check("skip_a_untouched", {27'd0, c1, n1}, 32'd0);
        check("skip_counts", {22'd0, leftA, leftB}, 32'd0);
        @(negedge clk);
        check("skip_game_over", {31'd0, game_over}, 32'd1);
        release dut.turn;
        exp_b = card_at(r_edge + 4);
        start = 1'b1; bell = 1'b1; resume = 1'b1;
        cycles(3);
        start = 1'b0; bell = 1'b0; resume = 1'b0;
        check("over_frozen", {14'd0, game_over, flip_valid, leftA, leftB, c1, n1, c2, n2},
              {14'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, exp_b});
        check("sb_empty_skip", sb.size(), 0);

        // Many games with varied start times; every dealt card is checked.
        for (int g = 0; g < 1000; g++) begin
            do_reset();
            cycles($urandom_range(0, 7));
            e0 = edge_cnt + 1;
            for (int k = 1; k <= 4; k++) push_flip(e0 + 4 * k, k[0] == 1'b0);
            start = 1'b1; @(negedge clk); start = 1'b0;
            wait_over($sformatf("game%0d_over", g), 30);
        end
        check("all_numbers_seen", {27'd0, seen}, {27'd0, 5'b11111});
        check("sb_empty_games", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
